pcie_ss_axis_tx_arb: RTL and testbench

PCIE_SS_AXIS_TX_ARB -- requirements
Module: pcie_ss_axis_tx_arb

---
 rtl/pcie_ss_axis_pkg.sv | 49 ++++
 rtl/pcie_ss_axis_rr_pick.sv | 30 +++
 rtl/pcie_ss_axis_tx_arb.sv | 148 ++++++++++++++
 tb/tb_pcie_ss_axis_tx_arb.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_ss_axis_pkg.sv
// Shared AXI-Stream types for the PCIe subsystem TX path.
//   axis_beat_t : one in-band-header packet beat, sized for the largest
//                 supported configuration; narrower users fill the low bits.
//   arb_state_t : packet-lock state of the TX arbiter.
//   rr_pick     : round-robin search over up to 8 requesters.
package pcie_ss_axis_pkg;

    localparam int AXIS_DATA_W = 512;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
    localparam int AXIS_USER_W = 1;
    localparam int RR_MAX_SRC  = 8;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic                   tlast;
        logic [AXIS_USER_W-1:0] tuser;
    } axis_beat_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Lowest requester strictly above 'last' wins; if none, wrap to the
    // lowest requester overall. Returns 0 when nothing requests.
    function automatic logic [2:0] rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                           input logic [2:0]            last);
        logic [RR_MAX_SRC-1:0] hi_req;
        logic [2:0]            idx;
        logic                  hit;
        idx = '0;
        hit = 1'b0;
        for (int i = 0; i < RR_MAX_SRC; i++)
            hi_req[i] = req[i] && (i > int'(last));
        for (int i = RR_MAX_SRC - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                idx = 3'(i);
                hit = 1'b1;
            end
        end
        if (!hit) begin
            for (int i = RR_MAX_SRC - 1; i >= 0; i--)
                if (req[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pcie_ss_axis_rr_pick.sv
// Combinational round-robin selector.
//   i_req   : per-source request vector
//   i_last  : index granted most recently
//   o_valid : at least one request present
//   o_idx   : selected source (meaningful only when o_valid=1)
module pcie_ss_axis_rr_pick
    import pcie_ss_axis_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         i_req,
    input  logic [$clog2(NUM_SRC)-1:0] i_last,
    output logic                       o_valid,
    output logic [$clog2(NUM_SRC)-1:0] o_idx
);
    localparam int GW = $clog2(NUM_SRC);

    logic [RR_MAX_SRC-1:0] w_req;
    logic [2:0]            w_last;

    always_comb begin
        w_req               = '0;
        w_req[NUM_SRC-1:0]  = i_req;
        w_last              = '0;
        w_last[GW-1:0]      = i_last;
        o_valid             = |i_req;
        o_idx               = GW'(rr_pick(w_req, w_last));
    end

endmodule

// File: rtl/pcie_ss_axis_tx_arb.sv
// Packet-locking round-robin arbiter merging NUM_SRC AXI-Stream sources onto
// one registered TX stream.
//   clk, rst_n                       : clock, async active-low reset
//   src_tvalid/src_tready            : per-source handshake
//   src_tdata/tkeep/tlast/tuser      : per-source beats, flattened source-major
//   src_en                           : per-source arbitration enable
//   tx_tvalid/tx_tready              : merged handshake
//   tx_tdata/tkeep/tlast/tuser       : merged beat (registered)
//   cur_grant, busy                  : locked source index, lock flag
//   pkt_cnt                          : packets forwarded on TX (wraps)
//
// state      | meaning
// ARB_IDLE   | no packet locked; pick and accept a first beat in one cycle
// ARB_LOCKED | continuing the packet from cur_grant until its tlast
module pcie_ss_axis_tx_arb
    import pcie_ss_axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int NUM_SRC     = 4,
    parameter int TUSER_WIDTH = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SRC-1:0]                 src_tvalid,
    output logic [NUM_SRC-1:0]                 src_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_tdata,
    input  logic [NUM_SRC*(DATA_WIDTH/8)-1:0]  src_tkeep,
    input  logic [NUM_SRC-1:0]                 src_tlast,
    input  logic [NUM_SRC*TUSER_WIDTH-1:0]     src_tuser,
    input  logic [NUM_SRC-1:0]                 src_en,
    output logic                               tx_tvalid,
    input  logic                               tx_tready,
    output logic [DATA_WIDTH-1:0]              tx_tdata,
    output logic [DATA_WIDTH/8-1:0]            tx_tkeep,
    output logic                               tx_tlast,
    output logic [TUSER_WIDTH-1:0]             tx_tuser,
    output logic [$clog2(NUM_SRC)-1:0]         cur_grant,
    output logic                               busy,
    output logic [15:0]                        pkt_cnt
);
    localparam int GW = $clog2(NUM_SRC);
    localparam int KW = DATA_WIDTH / 8;

    arb_state_t    r_state;
    logic [GW-1:0] r_last_grant;
    logic [GW-1:0] r_cur_grant;
    logic          r_busy;
    logic          r_tx_tvalid;
    axis_beat_t    r_beat;
    logic [15:0]   r_pkt_cnt;

    logic               w_pick_vld;
    logic [GW-1:0]      w_pick_idx;
    logic               w_out_ready;
    logic [GW-1:0]      w_sel_idx;
    logic               w_accept;
    logic [NUM_SRC-1:0] w_tready;
    axis_beat_t         w_beat;

    pcie_ss_axis_rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
        .i_req   (src_tvalid & src_en),
        .i_last  (r_last_grant),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    // rst_n gates src_tready so no source sees a handshake while held in reset.
    always_comb begin
        w_out_ready = !r_tx_tvalid || tx_tready;
        w_tready    = '0;
        if (r_state == ARB_IDLE) begin
            w_sel_idx = w_pick_idx;
            if (w_pick_vld && w_out_ready && rst_n)
                w_tready[w_pick_idx] = 1'b1;
        end else begin
            w_sel_idx = r_cur_grant;
            if (w_out_ready && rst_n)
                w_tready[r_cur_grant] = 1'b1;
        end
        w_accept = src_tvalid[w_sel_idx] && w_tready[w_sel_idx];

        w_beat                         = '0;
        w_beat.tdata[DATA_WIDTH-1:0]   = src_tdata[int'(w_sel_idx)*DATA_WIDTH +: DATA_WIDTH];
        w_beat.tkeep[KW-1:0]           = src_tkeep[int'(w_sel_idx)*KW +: KW];
        w_beat.tlast                   = src_tlast[w_sel_idx];
        w_beat.tuser[TUSER_WIDTH-1:0]  = src_tuser[int'(w_sel_idx)*TUSER_WIDTH +: TUSER_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= GW'(NUM_SRC - 1);
            r_cur_grant  <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept) begin
                        if (w_beat.tlast) begin
                            r_last_grant <= w_sel_idx;
                        end else begin
                            r_state     <= ARB_LOCKED;
                            r_cur_grant <= w_sel_idx;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (w_accept && w_beat.tlast) begin
                        r_state      <= ARB_IDLE;
                        r_last_grant <= r_cur_grant;
                        r_busy       <= 1'b0;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // Output stage only reloads on accept, so data holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_tvalid <= 1'b0;
            r_beat      <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_tx_tvalid <= 1'b1;
                r_beat      <= w_beat;
            end else if (tx_tready) begin
                r_tx_tvalid <= 1'b0;
            end
            if (r_tx_tvalid && tx_tready && r_beat.tlast)
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign src_tready = w_tready;
    assign tx_tvalid  = r_tx_tvalid;
    assign tx_tdata   = r_beat.tdata[DATA_WIDTH-1:0];
    assign tx_tkeep   = r_beat.tkeep[KW-1:0];
    assign tx_tlast   = r_beat.tlast;
    assign tx_tuser   = r_beat.tuser[TUSER_WIDTH-1:0];
    assign cur_grant  = r_cur_grant;
    assign busy       = r_busy;
    assign pkt_cnt    = r_pkt_cnt;

endmodule

// File: tb/tb_pcie_ss_axis_tx_arb.sv
module tb_pcie_ss_axis_tx_arb;
    localparam int DW = 512;
    localparam int NS = 4;
    localparam int UW = 1;
    localparam int KW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS-1:0]     src_tvalid, src_tready, src_tlast, src_en;
    logic [NS*DW-1:0]  src_tdata;
    logic [NS*KW-1:0]  src_tkeep;
    logic [NS*UW-1:0]  src_tuser;
    logic              tx_tvalid, tx_tready, tx_tlast;
    logic [DW-1:0]     tx_tdata;
    logic [KW-1:0]     tx_tkeep;
    logic [UW-1:0]     tx_tuser;
    logic [1:0]        cur_grant;
    logic              busy;
    logic [15:0]       pkt_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pcie_ss_axis_tx_arb #(.DATA_WIDTH(DW), .NUM_SRC(NS), .TUSER_WIDTH(UW)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_tvalid(src_tvalid), .src_tready(src_tready), .src_tdata(src_tdata),
        .src_tkeep(src_tkeep), .src_tlast(src_tlast), .src_tuser(src_tuser),
        .src_en(src_en),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tdata(tx_tdata),
        .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
        .cur_grant(cur_grant), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    task automatic set_src(input int s, input logic v, input logic [31:0] d, input logic l);
        src_tvalid[s]          = v;
        src_tdata[s*DW +: DW]  = {{(DW-32){1'b0}}, d};
        src_tkeep[s*KW +: KW]  = '1;
        src_tlast[s]           = l;
        src_tuser[s]           = 1'(s);
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        src_tvalid = '0;
        src_tdata  = '0;
        src_tkeep  = '0;
        src_tlast  = '0;
        src_tuser  = '0;
        src_en     = '1;
        tx_tready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        src_en = '1;
        tx_tready = 1'b1;
        for (int s = 0; s < NS; s++) set_src(s, 1'b1, 32'hA0 + 32'(s), 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (tx_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", tx_tvalid); end
        n_vec++; if (src_tready !== 4'b0000) begin n_err++; $display("FAIL reset_tready: got %b want 0000", src_tready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (cur_grant !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", cur_grant); end
        n_vec++; if (pkt_cnt !== 16'd0) begin n_err++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
        n_vec++; if (tx_tdata !== '0 || tx_tlast !== 1'b0 || tx_tkeep !== '0) begin n_err++; $display("FAIL reset_tx_beat: got data %0h last %b want 0", tx_tdata[31:0], tx_tlast); end
    endtask

    task automatic test_rr_single();
        logic [31:0] exp_d;
        apply_reset();
        for (int s = 0; s < NS; s++) set_src(s, 1'b1, 32'(s * 16), 1'b1);
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_d = 32'((k % 4) * 16);
            n_vec++; if (tx_tvalid !== 1'b1) begin n_err++; $display("FAIL rr_tvalid[%0d]: got %b want 1", k, tx_tvalid); end
            n_vec++; if (tx_tdata[31:0] !== exp_d) begin n_err++; $display("FAIL rr_order[%0d]: got %0h want %0h", k, tx_tdata[31:0], exp_d); end
            n_vec++; if (tx_tuser !== 1'((k % 4) & 1)) begin n_err++; $display("FAIL rr_tuser[%0d]: got %b want %0d", k, tx_tuser, (k % 4) & 1); end
            n_vec++; if (pkt_cnt !== 16'(k)) begin n_err++; $display("FAIL rr_pkt_cnt[%0d]: got %0d want %0d", k, pkt_cnt, k); end
            @(posedge clk);
        end
        #1 src_tvalid = '0;
        @(negedge clk);
        n_vec++; if (pkt_cnt !== 16'd8) begin n_err++; $display("FAIL rr_pkt_cnt_final: got %0d want 8", pkt_cnt); end
    endtask

    task automatic test_lock();
        apply_reset();
        for (int b = 0; b < 4; b++) begin
            set_src(1, 1'b1, 32'h10 + 32'(b), b == 3);
            if (b == 1) set_src(2, 1'b1, 32'h20, 1'b1);
            @(negedge clk);
            n_vec++; if (src_tready !== 4'b0010) begin n_err++; $display("FAIL lock_tready[%0d]: got %b want 0010", b, src_tready); end
            n_vec++; if (busy !== (b > 0)) begin n_err++; $display("FAIL lock_busy[%0d]: got %b want %0d", b, busy, b > 0); end
            if (b > 0) begin
                n_vec++; if (tx_tvalid !== 1'b1 || tx_tdata[31:0] !== 32'h10 + 32'(b - 1)) begin n_err++; $display("FAIL lock_tx[%0d]: got v%b %0h want %0h", b, tx_tvalid, tx_tdata[31:0], 32'h10 + b - 1); end
                n_vec++; if (cur_grant !== 2'd1) begin n_err++; $display("FAIL lock_grant[%0d]: got %0d want 1", b, cur_grant); end
            end
            @(posedge clk);
            #1;
        end
        set_src(1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        n_vec++; if (src_tready !== 4'b0100) begin n_err++; $display("FAIL lock_next_tready: got %b want 0100", src_tready); end
        n_vec++; if (tx_tdata[31:0] !== 32'h13 || tx_tlast !== 1'b1) begin n_err++; $display("FAIL lock_last_beat: got %0h/%b want 13/1", tx_tdata[31:0], tx_tlast); end
        @(posedge clk);
        #1 set_src(2, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        n_vec++; if (tx_tvalid !== 1'b1 || tx_tdata[31:0] !== 32'h20) begin n_err++; $display("FAIL lock_src2_beat: got v%b %0h want 20", tx_tvalid, tx_tdata[31:0]); end
    endtask

    task automatic test_stall();
        int sb, rcv, c;
        logic prev_stall;
        logic [31:0] prev_data;
        logic acc;
        apply_reset();
        sb = 0; rcv = 0; prev_stall = 1'b0; prev_data = '0;
        set_src(0, 1'b1, 32'h30, 1'b0);
        for (c = 0; c < 30 && rcv < 3; c++) begin
            tx_tready = (c % 2 == 0);
            @(negedge clk);
            if (prev_stall) begin
                n_vec++; if (tx_tvalid !== 1'b1 || tx_tdata[31:0] !== prev_data) begin n_err++; $display("FAIL stall_hold[%0d]: got v%b %0h want %0h", c, tx_tvalid, tx_tdata[31:0], prev_data); end
            end
            acc = src_tvalid[0] & src_tready[0];
            if (tx_tvalid && tx_tready) begin
                n_vec++; if (tx_tdata[31:0] !== 32'h30 + 32'(rcv) || tx_tlast !== (rcv == 2)) begin n_err++; $display("FAIL stall_beat[%0d]: got %0h/%b want %0h", rcv, tx_tdata[31:0], tx_tlast, 32'h30 + rcv); end
                rcv++;
            end
            prev_stall = tx_tvalid & !tx_tready;
            prev_data  = tx_tdata[31:0];
            @(posedge clk);
            #1;
            if (acc) begin
                sb++;
                if (sb < 3) set_src(0, 1'b1, 32'h30 + 32'(sb), sb == 2);
                else        set_src(0, 1'b0, 32'h0, 1'b0);
            end
        end
        n_vec++; if (rcv != 3) begin n_err++; $display("FAIL stall_count: got %0d beats want 3", rcv); end
        tx_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (tx_tvalid !== 1'b0) begin n_err++; $display("FAIL stall_extra[%0d]: got tvalid %b want 0", i, tx_tvalid); end
        end
        n_vec++; if (pkt_cnt !== 16'd1) begin n_err++; $display("FAIL stall_pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    task automatic test_src_en();
        apply_reset();
        for (int b = 0; b < 5; b++) begin
            set_src(0, 1'b1, 32'h40 + 32'(b), b == 4);
            if (b == 2) src_en[0] = 1'b0;
            @(negedge clk);
            n_vec++; if (src_tready !== 4'b0001) begin n_err++; $display("FAIL en_tready[%0d]: got %b want 0001", b, src_tready); end
            if (b > 0) begin
                n_vec++; if (tx_tvalid !== 1'b1 || tx_tdata[31:0] !== 32'h40 + 32'(b - 1)) begin n_err++; $display("FAIL en_beat[%0d]: got v%b %0h want %0h", b, tx_tvalid, tx_tdata[31:0], 32'h40 + b - 1); end
            end
            @(posedge clk);
            #1;
        end
        set_src(0, 1'b1, 32'h4F, 1'b1);
        set_src(1, 1'b1, 32'h50, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (src_tready !== 4'b0010) begin n_err++; $display("FAIL en_masked[%0d]: got %b want 0010", i, src_tready); end
            if (i == 0) begin
                n_vec++; if (tx_tdata[31:0] !== 32'h44 || tx_tlast !== 1'b1) begin n_err++; $display("FAIL en_last_beat: got %0h/%b want 44/1", tx_tdata[31:0], tx_tlast); end
            end
            @(posedge clk);
            #1;
        end
        src_en[0] = 1'b1;
        @(negedge clk);
        n_vec++; if (src_tready !== 4'b0001) begin n_err++; $display("FAIL en_regrant: got %b want 0001", src_tready); end
        @(posedge clk);
        #1 src_tvalid = '0;
        @(negedge clk);
        n_vec++; if (tx_tdata[31:0] !== 32'h4F) begin n_err++; $display("FAIL en_regrant_beat: got %0h want 4f", tx_tdata[31:0]); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_src(3, 1'b1, 32'h60, 1'b1);
        @(negedge clk);
        n_vec++; if (src_tready !== 4'b1000) begin n_err++; $display("FAIL rmid_src3: got %b want 1000", src_tready); end
        @(posedge clk);
        #1 set_src(3, 1'b0, 32'h0, 1'b0);
        set_src(2, 1'b1, 32'h70, 1'b0);
        @(posedge clk);
        #1 set_src(2, 1'b1, 32'h71, 1'b0);
        @(posedge clk);
        #1 set_src(2, 1'b1, 32'h72, 1'b0);
        set_src(0, 1'b1, 32'h80, 1'b1);
        #1;
        n_vec++; if (busy !== 1'b1 || pkt_cnt !== 16'd1) begin n_err++; $display("FAIL rmid_pre: got busy %b cnt %0d want 1/1", busy, pkt_cnt); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (tx_tvalid !== 1'b0) begin n_err++; $display("FAIL rmid_tvalid: got %b want 0", tx_tvalid); end
        n_vec++; if (busy !== 1'b0 || pkt_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_state: got busy %b cnt %0d want 0/0", busy, pkt_cnt); end
        n_vec++; if (src_tready !== 4'b0000) begin n_err++; $display("FAIL rmid_tready: got %b want 0000", src_tready); end
        @(posedge clk);
        #1 set_src(2, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (src_tready !== 4'b0001) begin n_err++; $display("FAIL rmid_first: got %b want 0001", src_tready); end
        @(posedge clk);
        #1 set_src(0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        n_vec++; if (tx_tvalid !== 1'b1 || tx_tdata[31:0] !== 32'h80) begin n_err++; $display("FAIL rmid_first_beat: got v%b %0h want 80", tx_tvalid, tx_tdata[31:0]); end
        @(negedge clk);
        n_vec++; if (tx_tvalid !== 1'b0) begin n_err++; $display("FAIL rmid_no_stale: got tvalid %b want 0", tx_tvalid); end
    endtask

    task automatic test_wrap();
        int iter;
        apply_reset();
        for (int s = 0; s < NS; s++) set_src(s, 1'b1, 32'(s), 1'b1);
        @(posedge clk);
        for (iter = 0; iter < 70000; iter++) begin
            @(negedge clk);
            if (pkt_cnt === 16'hFFFF) break;
            @(posedge clk);
        end
        n_vec++; if (iter != 65535) begin n_err++; $display("FAIL wrap_reach: reached ffff after %0d cycles want 65535", iter); end
        @(posedge clk);
        #1 src_tvalid = '0;
        @(negedge clk);
        n_vec++; if (pkt_cnt !== 16'd0) begin n_err++; $display("FAIL wrap_zero: got %0h want 0", pkt_cnt); end
    endtask

    initial begin
        rst_n      = 1'b0;
        src_tvalid = '0;
        src_tdata  = '0;
        src_tkeep  = '0;
        src_tlast  = '0;
        src_tuser  = '0;
        src_en     = '1;
        tx_tready  = 1'b1;
        test_reset();
        test_rr_single();
        test_lock();
        test_stall();
        test_src_en();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
